machine_trap_ctrl: RTL and testbench

Machine-mode trap controller on the core side of the external interrupt path. It consumes `mextern_int`/`custom_int_code` from the external interrupt controller, plus timer, software and synchronous-exception requests. It owns the trap CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval) and sequences trap entry and `mret` as a PC redirect handshake to the fetch stage. It sits between the interrupt controller and the core's commit/fetch logic.

---
 rtl/machine_trap_ctrl_pkg.sv | 55 +++++
 rtl/machine_trap_ctrl_trap_cause_sel.sv | 46 ++++
 rtl/machine_trap_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_machine_trap_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// bit positions, FSM state encoding, cause codes and the trap-target helper.
package XT_TRAP;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   // mstatus bit positions
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MSTATUS_MPP_LO   = 11;
   localparam int MSTATUS_MPP_HI   = 12;

   // mie / mip bit positions in the architectural CSR view
   localparam int MI_MSI_BIT = 3;
   localparam int MI_MTI_BIT = 7;
   localparam int MI_MEI_BIT = 11;

   // Index of each source in the compact 3-bit internal vectors
   localparam int IRQ_MSI = 0;
   localparam int IRQ_MTI = 1;
   localparam int IRQ_MEI = 2;

   // mcause interrupt codes (without the interrupt flag in bit 31)
   localparam logic [30:0] CAUSE_MEI         = 31'd11;
   localparam logic [30:0] CAUSE_MSI         = 31'd3;
   localparam logic [30:0] CAUSE_MTI         = 31'd7;
   localparam logic [30:0] CAUSE_CUSTOM_BASE = 31'd16;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_REDIRECT = 1'b1
   } trap_state_e;

   // Vectored mode only applies to interrupts; exceptions and direct mode use the base.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                               input logic        is_int,
                                               input logic [30:0] code);
      logic [31:0] base;
      logic [31:0] code32;
      base   = {mtvec[31:2], 2'b00};
      code32 = {1'b0, code};
      if (is_int && (mtvec[1:0] == 2'b01)) begin
         return base + (code32 << 2);
      end
      return base;
   endfunction

endpackage

// File: rtl/machine_trap_ctrl_trap_cause_sel.sv
// Combinational trap selection: priority between the synchronous exception
// and the enabled interrupt sources, mcause encoding and target PC.
module trap_cause_sel
   import XT_TRAP::*;
(
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic [2:0]  irq_lvl,
   input  logic [2:0]  irq_en,
   input  logic        mstatus_mie,
   input  logic [26:0] custom_int_code,
   input  logic [31:0] mtvec,
   output logic        take_exc,
   output logic        take_int,
   output logic [31:0] cause,
   output logic [31:0] target
);

   logic [2:0]  irq_pend;
   logic [30:0] int_code;
   logic [30:0] custom_code;

   // Priority: exception, then MEI, MSI, MTI; interrupts gated by global MIE
   always_comb begin
      irq_pend    = irq_lvl & irq_en;
      custom_code = {4'b0000, custom_int_code} + (CAUSE_CUSTOM_BASE - 31'd1);
      take_exc    = exc_req;
      take_int    = !exc_req && mstatus_mie && (irq_pend != 3'b000);

      int_code = CAUSE_MTI;
      if (irq_pend[IRQ_MEI]) begin
         int_code = (custom_int_code == 27'd0) ? CAUSE_MEI : custom_code;
      end else if (irq_pend[IRQ_MSI]) begin
         int_code = CAUSE_MSI;
      end

      if (exc_req) begin
         cause  = {27'd0, exc_code};
         target = trap_target(mtvec, 1'b0, int_code);
      end else begin
         cause  = {1'b1, int_code};
         target = trap_target(mtvec, 1'b1, int_code);
      end
   end

endmodule

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs, takes exceptions and
// interrupts at commit boundaries, executes mret, and holds a PC redirect
// towards fetch until it is accepted.
module machine_trap_ctrl
   import XT_TRAP::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        hb_clk,
   input  logic        rst_n,
   input  logic        mextern_int,
   input  logic [26:0] custom_int_code,
   input  logic        mtimer_int,
   input  logic        msoft_int,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic [31:0] commit_next_pc,
   input  logic        commit_exc,
   input  logic [4:0]  commit_exc_code,
   input  logic [31:0] commit_exc_tval,
   input  logic        commit_mret,
   input  logic        csr_we,
   input  logic        csr_re,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        trap_active
);

   trap_state_e state_q, state_d;
   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [2:0]  mie_en_q, mie_en_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] csr_rdata_q, csr_rdata_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        trap_active_q, trap_active_d;

   logic [2:0]  irq_lvl;
   logic        take_exc, take_int;
   logic [31:0] sel_cause, sel_target;
   logic [31:0] rd_val;

   // mip is a live, unlatched view of the three request levels
   assign irq_lvl = {mextern_int, mtimer_int, msoft_int};

   trap_cause_sel u_cause_sel (
      .exc_req         (commit_exc),
      .exc_code        (commit_exc_code),
      .irq_lvl         (irq_lvl),
      .irq_en          (mie_en_q),
      .mstatus_mie     (mstatus_mie_q),
      .custom_int_code (custom_int_code),
      .mtvec           (mtvec_q),
      .take_exc        (take_exc),
      .take_int        (take_int),
      .cause           (sel_cause),
      .target          (sel_target)
   );

   // CSR read mux over the current register contents (a same-cycle write is not visible)
   always_comb begin
      rd_val = 32'd0;
      case (csr_addr)
         CSR_MSTATUS: begin
            rd_val[MSTATUS_MIE_BIT]                = mstatus_mie_q;
            rd_val[MSTATUS_MPIE_BIT]               = mstatus_mpie_q;
            rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
         end
         CSR_MIE: begin
            rd_val[MI_MSI_BIT] = mie_en_q[IRQ_MSI];
            rd_val[MI_MTI_BIT] = mie_en_q[IRQ_MTI];
            rd_val[MI_MEI_BIT] = mie_en_q[IRQ_MEI];
         end
         CSR_MTVEC:  rd_val = mtvec_q;
         CSR_MEPC:   rd_val = mepc_q;
         CSR_MCAUSE: rd_val = mcause_q;
         CSR_MTVAL:  rd_val = mtval_q;
         CSR_MIP: begin
            rd_val[MI_MSI_BIT] = irq_lvl[IRQ_MSI];
            rd_val[MI_MTI_BIT] = irq_lvl[IRQ_MTI];
            rd_val[MI_MEI_BIT] = irq_lvl[IRQ_MEI];
         end
         default: rd_val = 32'd0;
      endcase
   end

   // Next-state: software CSR writes first, then trap/mret updates override the fields they touch
   always_comb begin
      state_d          = state_q;
      mstatus_mie_d    = mstatus_mie_q;
      mstatus_mpie_d   = mstatus_mpie_q;
      mie_en_d         = mie_en_q;
      mtvec_d          = mtvec_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mtval_d          = mtval_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      trap_active_d    = trap_active_q;
      csr_rdata_d      = csr_re ? rd_val : csr_rdata_q;

      if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
               mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
            end
            CSR_MIE: begin
               mie_en_d[IRQ_MSI] = csr_wdata[MI_MSI_BIT];
               mie_en_d[IRQ_MTI] = csr_wdata[MI_MTI_BIT];
               mie_en_d[IRQ_MEI] = csr_wdata[MI_MEI_BIT];
            end
            CSR_MTVEC:  mtvec_d  = csr_wdata;
            CSR_MEPC:   mepc_d   = csr_wdata & ~32'h3;
            CSR_MCAUSE: mcause_d = csr_wdata;
            CSR_MTVAL:  mtval_d  = csr_wdata;
            default: ;
         endcase
      end

      case (state_q)
         ST_RUN: begin
            if (commit_valid) begin
               if (take_exc || take_int) begin
                  mepc_d           = (take_exc ? commit_pc : commit_next_pc) & ~32'h3;
                  mcause_d         = sel_cause;
                  mtval_d          = take_exc ? commit_exc_tval : 32'd0;
                  mstatus_mpie_d   = mstatus_mie_q;
                  mstatus_mie_d    = 1'b0;
                  redirect_pc_d    = sel_target;
                  redirect_valid_d = 1'b1;
                  trap_active_d    = 1'b1;
                  state_d          = ST_REDIRECT;
               end else if (commit_mret) begin
                  mstatus_mie_d    = mstatus_mpie_q;
                  mstatus_mpie_d   = 1'b1;
                  redirect_pc_d    = mepc_q;
                  redirect_valid_d = 1'b1;
                  trap_active_d    = 1'b1;
                  state_d          = ST_REDIRECT;
               end
            end
         end
         ST_REDIRECT: begin
            // Commits are ignored here; the redirect target stays put until fetch takes it
            if (redirect_ready) begin
               redirect_valid_d = 1'b0;
               trap_active_d    = 1'b0;
               state_d          = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // FSM, CSR and registered-output state
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_RUN;
         mstatus_mie_q    <= 1'b0;
         mstatus_mpie_q   <= 1'b0;
         mie_en_q         <= 3'b000;
         mtvec_q          <= MTVEC_RESET;
         mepc_q           <= 32'd0;
         mcause_q         <= 32'd0;
         mtval_q          <= 32'd0;
         csr_rdata_q      <= 32'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
         trap_active_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         mstatus_mie_q    <= mstatus_mie_d;
         mstatus_mpie_q   <= mstatus_mpie_d;
         mie_en_q         <= mie_en_d;
         mtvec_q          <= mtvec_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mtval_q          <= mtval_d;
         csr_rdata_q      <= csr_rdata_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         trap_active_q    <= trap_active_d;
      end
   end

   assign csr_rdata      = csr_rdata_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign trap_active    = trap_active_q;

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Scoreboard bench for machine_trap_ctrl: expected CSR read data and
// redirect targets are queued when stimulus is driven and checked when
// the DUT presents them.
module tb_machine_trap_ctrl;
   import XT_TRAP::*;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

   logic        hb_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mextern_int = 1'b0;
   logic [26:0] custom_int_code = '0;
   logic        mtimer_int = 1'b0;
   logic        msoft_int = 1'b0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = '0;
   logic [31:0] commit_next_pc = '0;
   logic        commit_exc = 1'b0;
   logic [4:0]  commit_exc_code = '0;
   logic [31:0] commit_exc_tval = '0;
   logic        commit_mret = 1'b0;
   logic        csr_we = 1'b0;
   logic        csr_re = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready = 1'b0;
   logic        trap_active;

   machine_trap_ctrl #(.MTVEC_RESET(MTVEC_RST)) dut (
      .hb_clk          (hb_clk),
      .rst_n           (rst_n),
      .mextern_int     (mextern_int),
      .custom_int_code (custom_int_code),
      .mtimer_int      (mtimer_int),
      .msoft_int       (msoft_int),
      .commit_valid    (commit_valid),
      .commit_pc       (commit_pc),
      .commit_next_pc  (commit_next_pc),
      .commit_exc      (commit_exc),
      .commit_exc_code (commit_exc_code),
      .commit_exc_tval (commit_exc_tval),
      .commit_mret     (commit_mret),
      .csr_we          (csr_we),
      .csr_re          (csr_re),
      .csr_addr        (csr_addr),
      .csr_wdata       (csr_wdata),
      .csr_rdata       (csr_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .redirect_ready  (redirect_ready),
      .trap_active     (trap_active)
   );

   always #5 hb_clk = ~hb_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] rd_q[$];
   string       rd_tag_q[$];
   logic [31:0] redir_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: read data one cycle after csr_re, redirect target on each new redirect
   logic rd_pend = 1'b0;
   logic rv_prev = 1'b0;
   always @(posedge hb_clk) rd_pend <= csr_re;
   always @(negedge hb_clk) begin
      if (rd_pend && rd_q.size() > 0) begin
         chk(rd_tag_q.pop_front(), csr_rdata, rd_q.pop_front());
      end
      if (redirect_valid && !rv_prev) begin
         if (redir_q.size() > 0) chk("redirect_pc", redirect_pc, redir_q.pop_front());
         else chk("unexpected_redirect", {31'd0, redirect_valid}, 32'd0);
      end
      rv_prev <= redirect_valid;
   end

   task automatic tick();
      @(posedge hb_clk);
      #1;
   endtask

   task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_re   = 1'b1;
      csr_addr = a;
      rd_q.push_back(exp);
      rd_tag_q.push_back(tag);
      tick();
      csr_re = 1'b0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
      tick();
      csr_we = 1'b0;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [31:0] npc, input logic exc,
                         input logic [4:0] code, input logic [31:0] tval, input logic mret);
      commit_valid    = 1'b1;
      commit_pc       = pc;
      commit_next_pc  = npc;
      commit_exc      = exc;
      commit_exc_code = code;
      commit_exc_tval = tval;
      commit_mret     = mret;
      tick();
      commit_valid = 1'b0;
      commit_exc   = 1'b0;
      commit_mret  = 1'b0;
   endtask

   // Wait (bounded) for every queued expectation to be consumed by the monitor
   task automatic drain();
      for (int i = 0; i < 8; i++) begin
         if (rd_q.size() == 0 && redir_q.size() == 0) break;
         tick();
      end
      if (rd_q.size() != 0 || redir_q.size() != 0) begin
         chk("drain_timeout", rd_q.size() + redir_q.size(), 32'd0);
         rd_q.delete();
         rd_tag_q.delete();
         redir_q.delete();
      end
   endtask

   task automatic release_redirect();
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk("rv_after_ready", {31'd0, redirect_valid}, 32'd0);
      chk("ta_after_ready", {31'd0, trap_active}, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_trap_active", {31'd0, trap_active}, 32'd0);
      chk("rst_csr_rdata", csr_rdata, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      rst_n = 1'b1;
      tick();
      csr_rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
      csr_rd("rst_mtvec", CSR_MTVEC, 32'h0000_0100);
      csr_rd("rst_mcause", CSR_MCAUSE, 32'h0);
      csr_wr(12'h7C0, 32'hFFFF_FFFF);
      csr_rd("unlisted_csr", 12'h7C0, 32'h0);
      drain();

      // External interrupt with custom id, vectored mtvec
      csr_wr(CSR_MTVEC, 32'h0000_0201);
      csr_wr(CSR_MIE, 32'h0000_0800);
      csr_wr(CSR_MSTATUS, 32'h0000_0008);
      mextern_int     = 1'b1;
      custom_int_code = 27'd3;
      redir_q.push_back(32'h0000_0248);
      commit(32'h40, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0);
      drain();
      chk("mei_trap_active", {31'd0, trap_active}, 32'd1);
      csr_rd("mei_mcause", CSR_MCAUSE, 32'h8000_0012);
      csr_rd("mei_mepc", CSR_MEPC, 32'h0000_0044);
      csr_rd("mei_mtval", CSR_MTVAL, 32'h0);
      csr_rd("mei_mstatus", CSR_MSTATUS, 32'h0000_1880);
      csr_rd("mei_mip", CSR_MIP, 32'h0000_0800);
      drain();
      release_redirect();

      // Exception beats a pending MEI; goes to base even in vectored mode
      csr_wr(CSR_MSTATUS, 32'h0000_0008);
      redir_q.push_back(32'h0000_0200);
      commit(32'h80, 32'h84, 1'b1, 5'd2, 32'h0000_DEAD, 1'b0);
      drain();
      csr_rd("exc_mcause", CSR_MCAUSE, 32'h2);
      csr_rd("exc_mepc", CSR_MEPC, 32'h80);
      csr_rd("exc_mtval", CSR_MTVAL, 32'h0000_DEAD);
      csr_rd("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);
      drain();

      // Redirect held while ready is low; commits are ignored
      for (int i = 0; i < 5; i++) begin
         commit(32'h1000 + 32'(i) * 4, 32'h1004, i[0], 5'd7, 32'h1, !i[0]);
         chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
         chk("hold_pc", redirect_pc, 32'h0000_0200);
      end
      csr_rd("hold_mepc", CSR_MEPC, 32'h80);
      csr_rd("hold_mcause", CSR_MCAUSE, 32'h2);
      drain();
      release_redirect();

      // mret back to mepc (low bits of the written value are dropped)
      mextern_int = 1'b0;
      csr_wr(CSR_MEPC, 32'h0000_0046);
      csr_rd("mepc_align", CSR_MEPC, 32'h44);
      drain();
      redir_q.push_back(32'h0000_0044);
      commit(32'h90, 32'h94, 1'b0, 5'd0, 32'h0, 1'b1);
      drain();
      csr_rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
      drain();
      release_redirect();

      // CSR write to mstatus colliding with an exception: trap update wins
      csr_we          = 1'b1;
      csr_addr        = CSR_MSTATUS;
      csr_wdata       = 32'h0000_0008;
      redir_q.push_back(32'h0000_0200);
      commit(32'hA0, 32'hA4, 1'b1, 5'd5, 32'h55, 1'b0);
      csr_we = 1'b0;
      drain();
      csr_rd("coll_mstatus", CSR_MSTATUS, 32'h0000_1880);
      csr_rd("coll_mcause", CSR_MCAUSE, 32'h5);
      drain();
      release_redirect();

      // Pending MEI with MIE=0 never traps
      mextern_int = 1'b1;
      repeat (3) commit(32'hB0, 32'hB4, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("no_trap_mie0", {31'd0, redirect_valid}, 32'd0);
      csr_rd("mip_mei", CSR_MIP, 32'h0000_0800);
      drain();

      // MSI beats MTI, direct mode; enabling MIE in a commit cycle does not trap that cycle
      mextern_int = 1'b0;
      msoft_int   = 1'b1;
      mtimer_int  = 1'b1;
      csr_wr(CSR_MTVEC, 32'h0000_0300);
      csr_wr(CSR_MIE, 32'h0000_0888);
      csr_we    = 1'b1;
      csr_addr  = CSR_MSTATUS;
      csr_wdata = 32'h0000_0008;
      commit(32'hB0, 32'hB4, 1'b0, 5'd0, 32'h0, 1'b0);
      csr_we = 1'b0;
      chk("mie_write_no_trap", {31'd0, redirect_valid}, 32'd0);
      redir_q.push_back(32'h0000_0300);
      commit(32'hC0, 32'hC4, 1'b0, 5'd0, 32'h0, 1'b0);
      drain();
      csr_rd("msi_mcause", CSR_MCAUSE, 32'h8000_0003);
      csr_rd("msi_mepc", CSR_MEPC, 32'hC4);
      drain();

      // Asynchronous reset in the middle of a redirect
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_mid_active", {31'd0, trap_active}, 32'd0);
      msoft_int  = 1'b0;
      mtimer_int = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      csr_rd("post_rst_mepc", CSR_MEPC, 32'h0);
      csr_rd("post_rst_mtvec", CSR_MTVEC, 32'h0000_0100);
      csr_rd("post_rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
      drain();

      // MEI without custom id: cause 11, vectored target base + 44
      csr_wr(CSR_MTVEC, 32'h0000_0201);
      csr_wr(CSR_MIE, 32'h0000_0800);
      csr_wr(CSR_MSTATUS, 32'h0000_0008);
      mextern_int     = 1'b1;
      custom_int_code = 27'd0;
      redir_q.push_back(32'h0000_022C);
      commit(32'hD0, 32'hD4, 1'b0, 5'd0, 32'h0, 1'b0);
      drain();
      csr_rd("mei11_mcause", CSR_MCAUSE, 32'h8000_000B);
      drain();
      mextern_int = 1'b0;
      release_redirect();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
